cdc_hs_receiver: RTL
====================

Name: cdc_hs_receiver

Overview:
- Destination-side controller for a 4-phase REQ/ACK clock-domain-crossing handshake in the multi-clock system.
- Synchronizes the source-domain request through a multi-flop chain and captures the quasi-static source data bus into a one-deep output buffer.
- Presents the captured word to the local consumer with VALID/READY and returns ACK to the source domain.
- Sits between a source-domain handshake transmitter and destination logic such as the register file or ALU command path.

Parameters:
- DATA_WIDTH, 8, width of the transferred data word.
- STAGES, 2, number of synchronizer flops on REQ_ASYNC; legal range 2..4.
- CNT_WIDTH, 8, width of the accepted-transfer counter.

Ports:
- CLK  input  1  destination-domain clock.
- RST  input  1  asynchronous, active-low reset.
- REQ_ASYNC  input  1  request from the source domain; asynchronous to CLK.
- DATA_ASYNC  input  DATA_WIDTH  source data bus; stable from REQ rise until ACK is observed high.
- ACK  output  1  registered acknowledge to the source domain.
- OUT_DATA  output  DATA_WIDTH  captured word.
- OUT_VALID  output  1  OUT_DATA holds an unconsumed word.
- OUT_READY  input  1  consumer accepts the word when OUT_VALID and OUT_READY are both high at a CLK edge.
- BUSY  output  1  high while the FSM is not in IDLE.
- XFER_CNT  output  CNT_WIDTH  count of captured words; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (RST low, asynchronous):
  - Synchronizer chain cleared.
  - FSM forced to IDLE.
  - ACK=0, OUT_VALID=0, OUT_DATA=0, BUSY=0, XFER_CNT=0.
- Synchronizer: req_s is the last flop of an STAGES-deep chain. No logic sits between the chain flops.
- Buffer free condition: buf_free = !OUT_VALID || OUT_READY.
- FSM, two states:
  - IDLE: if req_s=1 and buf_free, then:
    - OUT_DATA <= DATA_ASYNC, OUT_VALID <= 1, ACK <= 1.
    - XFER_CNT increments.
    - Next state is ACKED.
    - Otherwise stay in IDLE with ACK=0. This is backpressure: the source is held by the missing ACK.
  - ACKED: ACK held at 1. When req_s=0, ACK <= 0 and next state is IDLE.
- DATA_ASYNC is sampled only in the capture cycle, never through the synchronizer.
- Latency: REQ_ASYNC first sampled high at edge 1 leads to OUT_VALID=1 and ACK=1 after edge STAGES+1, provided the buffer is free.
- ACK fall: occurs STAGES+1 edges after the first edge that samples REQ_ASYNC low.
- Consumer handshake:
  - A pop (OUT_VALID && OUT_READY) clears OUT_VALID.
  - A pop and a capture in the same cycle leave OUT_VALID=1 with the new data. No bubble and no loss.
- OUT_DATA is held stable while OUT_VALID=1 and the word is not popped.
- BUSY = (state==ACKED). It is a registered state decode, not a combinational path from any input.
- req_s staying high while in ACKED causes no second capture. Exactly one capture per REQ rising phase.
- A REQ glitch shorter than one CLK period may be missed. This is legal; the protocol requires the source to hold REQ until ACK.
- Reset mid-transfer: ACK drops immediately. If REQ_ASYNC is still high after reset release, the word is captured again and ACK re-asserts. The source tolerates ACK re-rise.
- XFER_CNT wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Decomposition:
- Shared package holds:
  - FSM state encodings IDLE=1'b0 and ACKED=1'b1.
  - Default-width localparams reused by the transmitter-side block.
- One sub-module, req_sync_ff:
  - Single-bit, STAGES-deep flop chain on CLK/RST, reset to 0.
  - Instantiated once for REQ_ASYNC.
  - The transmitter reuses it for ACK.

Test Plan:
- Basic transfer: reset, then REQ_ASYNC=1 with DATA_ASYNC=8'hA5 and OUT_READY=1 → OUT_VALID=1, OUT_DATA=A5, ACK=1 after edge 3. Then drop REQ → ACK=0 three edges later, XFER_CNT=1.
- Backpressure: OUT_READY=0, first word 8'h11 captured, second REQ with 8'h22 → ACK stays 0 and OUT_DATA stays 11. Raise OUT_READY → 22 is captured the same cycle 11 pops, and ACK=1 the following edge.
- Long REQ: hold REQ high for 20 cycles → exactly one capture, XFER_CNT increments by 1, BUSY=1 throughout.
- Counter wrap: 256 back-to-back transfers with CNT_WIDTH=8 → XFER_CNT returns to 0, all 256 data values are received in order.
- Reset mid-transfer: assert RST while in ACKED → ACK, OUT_VALID and XFER_CNT are 0 immediately. Release RST with REQ still high → recapture after STAGES+1 edges.
- STAGES=3 build: basic transfer repeated → OUT_VALID and ACK rise after edge 4.

Source files
------------

// File: rtl/cdc_hs_receiver_pkg.sv
// Shared definitions for the REQ/ACK clock-domain-crossing handshake blocks.
package cdc_hs_receiver_pkg;

    // Default widths, also used by the source-side transmitter
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_STAGES     = 2;
    localparam int unsigned DEF_CNT_WIDTH  = 8;

    // Receiver handshake states
    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } hs_state_e;

endpackage : cdc_hs_receiver_pkg

// File: rtl/req_sync_ff.sv
// Single-bit multi-flop synchronizer; plain flop chain with nothing between stages.
module req_sync_ff
    import cdc_hs_receiver_pkg::*;
#(
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the chain; cleared by reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : req_sync_ff

// File: rtl/cdc_hs_receiver.sv
// Destination side of a 4-phase REQ/ACK crossing: synchronizes REQ, captures the
// quasi-static source bus into a one-deep buffer and returns ACK to the source.
module cdc_hs_receiver
    import cdc_hs_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned STAGES     = DEF_STAGES,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_ASYNC,
    input  logic [DATA_WIDTH-1:0] DATA_ASYNC,
    output logic                  ACK,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  XFER_CNT
);

    hs_state_e             state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_s;
    logic                  pop_c;
    logic                  buf_free_c;

    // REQ crosses into CLK through the flop chain; DATA is never synchronized
    req_sync_ff #(
        .STAGES (STAGES)
    ) u_req_sync (
        .CLK (CLK),
        .RST (RST),
        .d_i (REQ_ASYNC),
        .q_o (req_s)
    );

    assign pop_c      = valid_q && OUT_READY;
    assign buf_free_c = !valid_q || OUT_READY;

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake sequencing; a pop and a capture in the same cycle keep VALID high
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        if (pop_c) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_s && buf_free_c) begin
                    data_d  = DATA_ASYNC;
                    valid_d = 1'b1;
                    ack_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = ACKED;
                end
            end
            ACKED: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    assign ACK       = ack_q;
    assign OUT_DATA  = data_q;
    assign OUT_VALID = valid_q;
    assign BUSY      = (state_q == ACKED);
    assign XFER_CNT  = cnt_q;

endmodule : cdc_hs_receiver
